// File: rtl/fft_sequencer.sv
// fft_sequencer
//   Control sequencer for a radix-2 in-place DIT FFT. It carries no sample
//   data. It produces RAM addresses and strobes for four jobs:
//     - loading N samples in bit-reversed order,
//     - scheduling every butterfly (addresses + twiddle index),
//     - mirroring each issue as a writeback BF_LAT cycles later,
//     - reading the results back out in natural order.
//
// Ports
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   start                      begin a transform (only honoured in IDLE)
//   in_valid / in_ready        upstream sample handshake
//   ld_we, ld_addr             RAM write strobe and bit-reversed address for a sample
//   bf_issue, bf_addr_a/b      butterfly issue strobe and the two leg addresses
//   bf_tw                      twiddle ROM index k of W_N^k
//   wb_en, wb_addr_a/b         butterfly writeback strobe and addresses
//   out_valid / out_ready      downstream result handshake
//   rd_addr                    natural-order RAM read address
//   busy, done                 activity flag; one-cycle pulse after the last output
//
// Timing notes
//   The bf_*, wb_*, busy and done outputs are registered.
//   The in_ready, ld_we, ld_addr, out_valid and rd_addr outputs are combinational.
//   done rises in the cycle after the final output transfer, when the FSM is
//   already back in IDLE. busy stays high through that cycle and falls one
//   cycle later. A start that arrives while done is high is ignored.
module fft_sequencer #(
    parameter int LOG2N  = 3,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ld_we,
    output logic [LOG2N-1:0] ld_addr,
    output logic             bf_issue,
    output logic [LOG2N-1:0] bf_addr_a,
    output logic [LOG2N-1:0] bf_addr_b,
    output logic [LOG2N-2:0] bf_tw,
    output logic             wb_en,
    output logic [LOG2N-1:0] wb_addr_a,
    output logic [LOG2N-1:0] wb_addr_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] rd_addr,
    output logic             busy,
    output logic             done
);
    localparam int N  = 1 << LOG2N;
    localparam int SW = 3;               // stage counter width, covers LOG2N <= 6
    localparam int PW = 2 * LOG2N + 1;   // writeback pipe entry {issue, a, b}

    localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] J_LAST = LOG2N'(N / 2 - 1);
    localparam logic [LOG2N-1:0] D_LAST = LOG2N'(BF_LAT - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, UNLOAD} state_t;

    state_t                       state_q, state_d;
    logic [LOG2N-1:0]             cnt_q, cnt_d;      // k in LOAD/UNLOAD, j in COMPUTE, drain count
    logic [SW-1:0]                stage_q, stage_d;
    logic                         bf_issue_q, bf_issue_d;
    logic [LOG2N-1:0]             bf_addr_a_q, bf_addr_a_d;
    logic [LOG2N-1:0]             bf_addr_b_q, bf_addr_b_d;
    logic [LOG2N-2:0]             bf_tw_q, bf_tw_d;
    logic [BF_LAT-1:0][PW-1:0]    wb_pipe_q, wb_pipe_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [LOG2N-1:0] half, pos, grp, addr_a;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stage_q     <= '0;
            bf_issue_q  <= 1'b0;
            bf_addr_a_q <= '0;
            bf_addr_b_q <= '0;
            bf_tw_q     <= '0;
            wb_pipe_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            bf_issue_q  <= bf_issue_d;
            bf_addr_a_q <= bf_addr_a_d;
            bf_addr_b_q <= bf_addr_b_d;
            bf_tw_q     <= bf_tw_d;
            wb_pipe_q   <= wb_pipe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                // done_q high means we just left UNLOAD; that start is ignored
                if (start && !done_q) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt_q == K_LAST) begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == J_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LOG2N'(1);
                end
            end
            DRAIN: begin
                // BF_LAT idle cycles so the last writeback of this stage
                // lands before the next stage's first read
                if (cnt_q == D_LAST) begin
                    cnt_d = '0;
                    if (stage_q == S_LAST) begin
                        state_d = UNLOAD;
                    end else begin
                        state_d = COMPUTE;
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + LOG2N'(1);
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (cnt_q == K_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == LOAD);
        ld_we     = in_ready && in_valid;
        ld_addr   = in_ready ? bitrev(cnt_q) : '0;
        out_valid = (state_q == UNLOAD);
        rd_addr   = out_valid ? cnt_q : '0;

        // Butterfly addressing for stage s, butterfly j:
        //   a  = grp*2*half + pos
        //   b  = a + half
        //   tw = pos << (LOG2N-1-s)
        half   = LOG2N'(1) << stage_q;
        pos    = cnt_q & (half - LOG2N'(1));
        grp    = cnt_q >> stage_q;
        addr_a = (grp << (stage_q + SW'(1))) | pos;

        bf_issue_d  = (state_q == COMPUTE);
        bf_addr_a_d = '0;
        bf_addr_b_d = '0;
        bf_tw_d     = '0;
        if (bf_issue_d) begin
            bf_addr_a_d = addr_a;
            bf_addr_b_d = addr_a + half;
            // pos < N/2, so the shifted value always fits LOG2N-1 bits
            bf_tw_d     = pos[LOG2N-2:0] << (S_LAST - stage_q);
        end

        wb_pipe_d    = wb_pipe_q;
        wb_pipe_d[0] = {bf_issue_q, bf_addr_a_q, bf_addr_b_q};
        for (int i = 1; i < BF_LAT; i++) wb_pipe_d[i] = wb_pipe_q[i-1];

        done_d = (state_q == UNLOAD) && out_ready && (cnt_q == K_LAST);
        busy_d = (state_d != IDLE) || done_d;
    end

    assign bf_issue  = bf_issue_q;
    assign bf_addr_a = bf_addr_a_q;
    assign bf_addr_b = bf_addr_b_q;
    assign bf_tw     = bf_tw_q;
    assign wb_en     = wb_pipe_q[BF_LAT-1][PW-1];
    assign wb_addr_a = wb_pipe_q[BF_LAT-1][PW-2 -: LOG2N];
    assign wb_addr_b = wb_pipe_q[BF_LAT-1][LOG2N-1:0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
